toggle_sched: RTL
=================

# toggle_sched

Programmable toggle scheduler that generates a divided, gated square-wave `clk_out` from the system clock, replacing free-running `always #N clk = ~clk` stimulus with a synthesizable, configurable source. It sequences start, stop and finite-burst operation and guarantees no truncated high phase on stop. It feeds clock-enable and strobe consumers elsewhere in the design.

## Interface
- `CNT_W`, 16, width of half-period and period-count fields
- `DEF_HALF`, 10, reset value of half-period register (input cycles per phase)

- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `cfg_valid`  in  1  configuration offer
- `cfg_ready`  out  1  configuration accepted when `cfg_valid && cfg_ready`
- `cfg_half`  in  CNT_W  half-period in input cycles; 0 treated as 1
- `cfg_cycles`  in  CNT_W  full periods per burst; 0 = continuous
- `start`  in  1  begin toggling (level sampled per cycle)
- `stop`  in  1  request graceful stop
- `clk_out`  out  1  generated square wave, registered
- `edge_rise`  out  1  one-cycle pulse, same cycle `clk_out` becomes 1
- `edge_fall`  out  1  one-cycle pulse, same cycle `clk_out` becomes 0
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle pulse on return to IDLE

## Operation
- States: IDLE, RUN, DRAIN.
- Registers: `half_reg` (reset DEF_HALF), `cyc_reg` (reset 0), down-counter `cnt`, period counter `per`.
- IDLE: `clk_out`=0, `cfg_ready`=1; config handshake loads `half_reg`/`cyc_reg` (0 half stored as 1). `start` && !`stop` → RUN, `cnt`←`half_reg`-1, `per`←0. `start` && `stop` together: stay IDLE. Config and start in same cycle: new config used.
- RUN/DRAIN: `cfg_ready`=0; `cfg_valid` ignored (no accept). Each cycle `cnt` decrements; when `cnt`==0: toggle `clk_out`, reload `half_reg`-1.
- On each falling toggle in RUN: `per`++; if `cyc_reg`!=0 and new `per`==`cyc_reg` → IDLE, `done`.
- `stop` in RUN: if `clk_out`==0 and no toggle this cycle → IDLE next edge, `done`; otherwise → DRAIN. Stop coinciding with a rising toggle → DRAIN.
- DRAIN: keep counting; at falling toggle → IDLE, `done`. No further rising edge permitted.
- `start` outside IDLE ignored; `stop` in IDLE/DRAIN ignored.
- `per` comparison width CNT_W; `per` never exceeds `cyc_reg` in burst mode; in continuous mode wraps silently.

## Timing
- Reset (async assert, sync-to-clk deassert by upstream): state IDLE, `clk_out`=0, `edge_rise`=`edge_fall`=0, `busy`=0, `done`=0, `cfg_ready`=1, `cnt`=0, `per`=0.
- Start accepted at edge k: `busy`=1 after k; first rise at edge k+`half_reg`; period 2·`half_reg` cycles, 50% duty.
- Burst of N periods: last fall at k+2N·`half_reg`; `done` high and `busy` low the same cycle.
- Edges/`done` are registered alongside `clk_out`; zero combinational paths input→output except none (all outputs registered).
- Reset mid-run: `clk_out` drops to 0 immediately, no `done` pulse.
- `half_reg`=1: `clk_out` toggles every cycle.

## Structure
- Package `toggle_sched_pkg`: state enum (IDLE, RUN, DRAIN), `DEF_HALF` default, CNT_W default.
- One sub-module natural: `half_cnt` — loadable down-counter with zero flag, instanced for `cnt`.

## Test plan
- Reset defaults, start with no config → rise at 10 cycles, fall at 20; period 20, continuous until stop.
- Config half=3, cycles=4, start → 4 periods of 6 cycles, `done` at cycle 24 with final fall, `busy` low.
- Half=5 continuous, assert `stop` 2 cycles after a rise → DRAIN, high phase completes full 5 cycles, `done` at fall, no further rise.
- `stop` during low phase → IDLE next cycle, `done` pulse, `clk_out` stays 0.
- Config half=0 → toggles every cycle; `cfg_valid` during RUN → `cfg_ready`=0, config unchanged after stop.
- `start`+`stop` same cycle in IDLE → stays IDLE; async reset mid-high-phase → `clk_out`=0 immediately, no `done`.

Source files
------------

// File: rtl/toggle_sched_pkg.sv
// -----------------------------------------------------------------------------
// toggle_sched_pkg
// Shared types and default parameters for the toggle scheduler.
//   state_t       : scheduler state (IDLE, RUN, DRAIN)
//   CNT_W_DEF     : default width of half-period / period-count fields
//   DEF_HALF_DEF  : default reset value of the half-period register
// -----------------------------------------------------------------------------
package toggle_sched_pkg;

    localparam int CNT_W_DEF    = 16;
    localparam int DEF_HALF_DEF = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/toggle_sched_half_cnt.sv
// -----------------------------------------------------------------------------
// half_cnt
// Loadable down-counter with zero flag; times each half-period of clk_out.
// Ports:
//   clk, rst_n : clock / asynchronous active-low reset
//   load       : load load_val (has priority over counting)
//   load_val   : value to load
//   en         : decrement while non-zero
//   cnt        : current count (registered)
//   zero       : cnt == 0
// -----------------------------------------------------------------------------
module half_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/toggle_sched.sv
// -----------------------------------------------------------------------------
// toggle_sched
// Programmable divided / gated square-wave generator with start, graceful stop
// and finite-burst operation. All outputs are registered.
// Ports:
//   clk, rst_n            : system clock / asynchronous active-low reset
//   cfg_valid, cfg_ready  : configuration handshake (accepted only in IDLE)
//   cfg_half              : half-period in clk cycles (0 stored as 1)
//   cfg_cycles            : periods per burst (0 = continuous)
//   start, stop           : begin toggling / request graceful stop
//   clk_out               : generated square wave
//   edge_rise, edge_fall  : one-cycle pulses coincident with clk_out edges
//   busy                  : scheduler not idle
//   done                  : one-cycle pulse on return to IDLE
// -----------------------------------------------------------------------------
module toggle_sched
    import toggle_sched_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int DEF_HALF = DEF_HALF_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_half,
    input  logic [CNT_W-1:0] cfg_cycles,
    input  logic             start,
    input  logic             stop,
    output logic             clk_out,
    output logic             edge_rise,
    output logic             edge_fall,
    output logic             busy,
    output logic             done
);

    state_t             state_reg;
    logic [CNT_W-1:0]   half_reg;
    logic [CNT_W-1:0]   cyc_reg;
    logic [CNT_W-1:0]   per_reg;
    logic [CNT_W-1:0]   cnt;
    logic               cnt_zero;

    logic               cfg_fire;
    logic [CNT_W-1:0]   half_in;
    logic [CNT_W-1:0]   eff_half;
    logic               start_go;
    logic               running;
    logic               tick;
    logic               rise_t;
    logic               fall_t;
    logic [CNT_W-1:0]   per_next;
    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_load_val;

    // cfg_ready is registered as (state == IDLE), so it doubles as the accept gate.
    assign cfg_fire = cfg_valid && cfg_ready;
    assign half_in  = (cfg_half == '0) ? CNT_W'(1) : cfg_half;
    // A config accepted in the same cycle as start takes effect immediately.
    assign eff_half = cfg_fire ? half_in : half_reg;
    assign start_go = (state_reg == IDLE) && start && !stop;
    assign running  = (state_reg != IDLE);
    assign tick     = running && cnt_zero;
    assign rise_t   = tick && !clk_out;
    assign fall_t   = tick && clk_out;
    assign per_next = per_reg + CNT_W'(1);

    assign cnt_load     = start_go || tick;
    assign cnt_load_val = start_go ? (eff_half - CNT_W'(1)) : (half_reg - CNT_W'(1));

    half_cnt #(.W(CNT_W)) u_half_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (running),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            half_reg  <= CNT_W'(DEF_HALF);
            cyc_reg   <= '0;
            per_reg   <= '0;
            clk_out   <= 1'b0;
            edge_rise <= 1'b0;
            edge_fall <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_ready <= 1'b1;
        end else begin
            edge_rise <= 1'b0;
            edge_fall <= 1'b0;
            done      <= 1'b0;
            unique case (state_reg)
                IDLE: begin
                    if (cfg_fire) begin
                        half_reg <= half_in;
                        cyc_reg  <= cfg_cycles;
                    end
                    if (start_go) begin
                        state_reg <= RUN;
                        per_reg   <= '0;
                        busy      <= 1'b1;
                        cfg_ready <= 1'b0;
                    end
                end
                RUN: begin
                    if (tick) begin
                        clk_out   <= !clk_out;
                        edge_rise <= rise_t;
                        edge_fall <= fall_t;
                    end
                    if (fall_t) begin
                        per_reg <= per_next;
                        // A stop landing on the falling toggle has nothing left
                        // to drain: the high phase just completed.
                        if (((cyc_reg != '0) && (per_next == cyc_reg)) || stop) begin
                            state_reg <= IDLE;
                            busy      <= 1'b0;
                            cfg_ready <= 1'b1;
                            done      <= 1'b1;
                        end
                    end else if (stop) begin
                        if (!clk_out && !tick) begin
                            state_reg <= IDLE;
                            busy      <= 1'b0;
                            cfg_ready <= 1'b1;
                            done      <= 1'b1;
                        end else begin
                            // High phase in progress or just starting: finish it.
                            state_reg <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // clk_out is high throughout DRAIN, so the only toggle is the fall.
                    if (tick) begin
                        clk_out   <= 1'b0;
                        edge_fall <= 1'b1;
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                        cfg_ready <= 1'b1;
                        done      <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    clk_out   <= 1'b0;
                    busy      <= 1'b0;
                    cfg_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
